// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 initiator.
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_state_t;

    // Bit positions within pprot as defined by APB4.
    localparam int PPROT_PRIVILEGED  = 0;
    localparam int PPROT_NONSECURE   = 1;
    localparam int PPROT_INSTRUCTION = 2;

endpackage

// File: rtl/apb4_master_timer.sv
// Saturating ACCESS wait counter; expire pulses on the last permitted wait cycle.
module apb4_master_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT_CYCLES);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (enable && (count_q != MAX)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire = enable && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb4_master.sv
// APB4 initiator: one command at a time through SETUP/ACCESS, response held until consumed.
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wr_data,
    input  logic [DATA_WIDTH/8-1:0] cmd_wr_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rd_data,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    apb_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [2:0]              prot_q, prot_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    err_q, err_d;
    logic                    timeout_q, timeout_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expire;

    apb4_master_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        prot_d      = prot_q;
        wr_d        = wr_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        cmd_ready   = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wr_data;
                    // Reads must present all-zero strobes on the bus.
                    strb_d      = cmd_is_wr ? cmd_wr_strb : '0;
                    prot_d      = cmd_prot;
                    wr_d        = cmd_is_wr;
                    rd_data_d   = '0;
                    err_d       = 1'b0;
                    timeout_d   = 1'b0;
                    timer_clear = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    err_d     = pslverr;
                    timeout_d = 1'b0;
                    rd_data_d = wr_q ? '0 : prdata;
                    state_d   = RESP;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        rd_data_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            wr_q      <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign paddr       = addr_q;
    assign pwrite      = wr_q;
    assign pwdata      = wdata_q;
    assign pstrb       = strb_q;
    assign pprot       = prot_q;
    assign rsp_rd_data = rd_data_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master with hand-computed expectations checked by immediate assertions.
module tb_apb4_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_wr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wr_data;
    logic [3:0]  cmd_wr_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int compared   = 0;
    int mismatched = 0;
    int access_cycles;

    apb4_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_is_wr   (cmd_is_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wr_data (cmd_wr_data),
        .cmd_wr_strb (cmd_wr_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd_data (rsp_rd_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one command and returns just after its handshake edge (SETUP cycle).
    task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [2:0] prot);
        cmd_valid   = 1'b1;
        cmd_is_wr   = wr;
        cmd_addr    = addr;
        cmd_wr_data = data;
        cmd_wr_strb = strb;
        cmd_prot    = prot;
        tick();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_is_wr   = 1'b0;
        cmd_addr    = '0;
        cmd_wr_data = '0;
        cmd_wr_strb = '0;
        cmd_prot    = '0;
        rsp_ready   = 1'b1;
        prdata      = '0;
        pready      = 1'b0;
        pslverr     = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_paddr", paddr, 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_cmd_ready", cmd_ready, 1);

        // Write, zero wait states
        pready = 1'b1;
        applyStimulus(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b010);
        checkOutput("wr_setup_psel", psel, 1);
        checkOutput("wr_setup_penable", penable, 0);
        checkOutput("wr_setup_pwrite", pwrite, 1);
        checkOutput("wr_setup_pstrb", pstrb, 32'hF);
        checkOutput("wr_setup_paddr", paddr, 32'h04);
        checkOutput("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
        checkOutput("wr_setup_pprot", pprot, 32'h2);
        checkOutput("wr_setup_cmd_ready", cmd_ready, 0);
        tick();
        checkOutput("wr_access_psel", psel, 1);
        checkOutput("wr_access_penable", penable, 1);
        checkOutput("wr_access_rsp_valid", rsp_valid, 0);
        tick();
        checkOutput("wr_rsp_valid", rsp_valid, 1);
        checkOutput("wr_rsp_err", rsp_err, 0);
        checkOutput("wr_rsp_rd_data", rsp_rd_data, 0);
        checkOutput("wr_rsp_psel", psel, 0);
        tick();
        checkOutput("wr_after_cmd_ready", cmd_ready, 1);
        checkOutput("wr_after_rsp_valid", rsp_valid, 0);

        // Read, three wait states
        pready = 1'b0;
        prdata = 32'hAAAAAAAA;
        applyStimulus(1'b0, 8'h08, 32'h11111111, 4'hF, 3'b000);
        checkOutput("rd_setup_pstrb", pstrb, 0);
        checkOutput("rd_setup_pwrite", pwrite, 0);
        checkOutput("rd_setup_paddr", paddr, 32'h08);
        tick();
        checkOutput("rd_access1_penable", penable, 1);
        tick();
        tick();
        tick();
        checkOutput("rd_access4_penable", penable, 1);
        checkOutput("rd_access4_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        prdata = 32'h12345678;
        tick();
        pready = 1'b0;
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_rd_data", rsp_rd_data, 32'h12345678);
        checkOutput("rd_rsp_err", rsp_err, 0);
        tick();

        // Slave error on read
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h00000055;
        applyStimulus(1'b0, 8'h10, 32'h0, 4'h0, 3'b001);
        tick();
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        checkOutput("serr_rsp_valid", rsp_valid, 1);
        checkOutput("serr_rsp_err", rsp_err, 1);
        checkOutput("serr_rsp_timeout", rsp_timeout, 0);
        checkOutput("serr_rsp_rd_data", rsp_rd_data, 32'h55);
        tick();

        // Timeout with pready held low
        prdata = 32'hFFFFFFFF;
        access_cycles = 0;
        applyStimulus(1'b0, 8'h0C, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (psel && penable) access_cycles++;
            tick();
        end
        checkOutput("to_access_cycles", access_cycles, 16);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_psel", psel, 0);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_timeout", rsp_timeout, 1);
        checkOutput("to_rsp_rd_data", rsp_rd_data, 0);
        tick();

        // pready on the 16th ACCESS cycle completes normally
        applyStimulus(1'b0, 8'h14, 32'h0, 4'h0, 3'b000);
        tick();
        for (int i = 0; i < 15; i++) tick();
        checkOutput("edge_access16_penable", penable, 1);
        pready = 1'b1;
        prdata = 32'h00000077;
        tick();
        pready = 1'b0;
        checkOutput("edge_rsp_valid", rsp_valid, 1);
        checkOutput("edge_rsp_err", rsp_err, 0);
        checkOutput("edge_rsp_timeout", rsp_timeout, 0);
        checkOutput("edge_rsp_rd_data", rsp_rd_data, 32'h77);
        tick();

        // Response backpressure
        rsp_ready = 1'b0;
        pready    = 1'b1;
        applyStimulus(1'b1, 8'h20, 32'hCAFEF00D, 4'h3, 3'b000);
        tick();
        tick();
        pready = 1'b0;
        checkOutput("bp_rsp_valid0", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_rsp_valid", rsp_valid, 1);
            checkOutput("bp_rsp_err", rsp_err, 0);
            checkOutput("bp_rsp_rd_data", rsp_rd_data, 0);
            checkOutput("bp_cmd_ready", cmd_ready, 0);
            checkOutput("bp_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_after_cmd_ready", cmd_ready, 1);
        checkOutput("bp_after_rsp_valid", rsp_valid, 0);

        // Reset during an ACCESS wait state
        applyStimulus(1'b1, 8'h30, 32'h0BADF00D, 4'hF, 3'b111);
        tick();
        tick();
        checkOutput("mrst_wait_penable", penable, 1);
        rst = 1'b1;
        tick();
        checkOutput("mrst_psel", psel, 0);
        checkOutput("mrst_penable", penable, 0);
        checkOutput("mrst_paddr", paddr, 0);
        checkOutput("mrst_pwrite", pwrite, 0);
        checkOutput("mrst_pwdata", pwdata, 0);
        checkOutput("mrst_pstrb", pstrb, 0);
        checkOutput("mrst_pprot", pprot, 0);
        checkOutput("mrst_cmd_ready", cmd_ready, 0);
        checkOutput("mrst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mrst_no_rsp", rsp_valid, 0);
        end
        checkOutput("mrst_idle_cmd_ready", cmd_ready, 1);

        // Command after reset completes normally
        pready = 1'b1;
        applyStimulus(1'b1, 8'h3C, 32'h01020304, 4'hF, 3'b000);
        checkOutput("post_setup_paddr", paddr, 32'h3C);
        tick();
        tick();
        pready = 1'b0;
        checkOutput("post_rsp_valid", rsp_valid, 1);
        checkOutput("post_rsp_err", rsp_err, 0);
        checkOutput("post_rsp_timeout", rsp_timeout, 0);
        tick();
        checkOutput("post_cmd_ready", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
